// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared types, grid geometry and helpers for the life generation sequencer
package life_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_CALC   = 2'd2,
    ST_COMMIT = 2'd3
  } life_state_t;

  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int GRID_W = ROWS * COLS;

  localparam logic [GRID_W-1:0] DEFAULT_SEED = 64'h0412_6424_0034_3C28;

  // Row r occupies bits r*8+7 .. r*8.
  function automatic logic [COLS-1:0] get_row(input logic [GRID_W-1:0] g,
                                               input logic [2:0]        r);
    return g[{r, 3'b000} +: COLS];
  endfunction

endpackage

// File: rtl/life_row_eval.sv
// rtl/life_row_eval.sv - combinational next-state of one grid row, columns wrap toroidally
module life_row_eval
  import life_pkg::*;
(
  input  logic [COLS-1:0] above,
  input  logic [COLS-1:0] cur,
  input  logic [COLS-1:0] below,
  output logic [COLS-1:0] next_row
);

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int CL = (c + COLS - 1) % COLS;
    localparam int CR = (c + 1) % COLS;

    logic [3:0] cnt;

    assign cnt = {3'b000, above[CL]} + {3'b000, above[c]} + {3'b000, above[CR]}
               + {3'b000, cur[CL]}                         + {3'b000, cur[CR]}
               + {3'b000, below[CL]} + {3'b000, below[c]} + {3'b000, below[CR]};

    assign next_row[c] = (cnt == 4'd3) | (cur[c] & (cnt == 4'd2));
  end

endmodule

// File: rtl/life_gen_controller.sv
// rtl/life_gen_controller.sv - owns the grid, paces generations and evaluates them one row per cycle
module life_gen_controller
  import life_pkg::*;
#(
  parameter int TICK_DIV = 12_500_000,
  parameter int GEN_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              randomize,
  input  logic              pause,
  input  logic [GRID_W-1:0] seed_in,
  output logic [GRID_W-1:0] grid,
  output logic              running,
  output logic              busy,
  output logic              stable,
  output logic [GEN_W-1:0]  gen_count
);

  localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  life_state_t       state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [2:0]        row_q, row_d;
  logic [GRID_W-1:0] grid_q, grid_d;
  logic [GRID_W-1:0] shadow_q, shadow_d;
  logic [GEN_W-1:0]  gen_q, gen_d;
  logic              stable_q, stable_d;
  logic [COLS-1:0]   next_row;

  // Neighbour rows always come from the committed grid; the 3-bit index wraps mod 8.
  life_row_eval u_row_eval (
    .above    (get_row(grid_q, row_q - 3'd1)),
    .cur      (get_row(grid_q, row_q)),
    .below    (get_row(grid_q, row_q + 3'd1)),
    .next_row (next_row)
  );

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    row_d    = row_q;
    grid_d   = grid_q;
    shadow_d = shadow_q;
    gen_d    = gen_q;
    stable_d = stable_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WAIT;
          tick_d  = '0;
        end
      end
      ST_WAIT: begin
        if (!pause) begin
          if (tick_q == TICK_LAST) begin
            state_d = ST_CALC;
            tick_d  = '0;
            row_d   = 3'd0;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      ST_CALC: begin
        shadow_d[{row_q, 3'b000} +: COLS] = next_row;
        row_d = row_q + 3'd1;
        if (row_q == 3'd7) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        grid_d   = shadow_q;
        gen_d    = gen_q + 1'b1;
        stable_d = (shadow_q == grid_q);
        state_d  = (shadow_q == grid_q) ? ST_IDLE : ST_WAIT;
        tick_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    // A reload overrides everything, including a pending commit.
    if (randomize) begin
      state_d  = ST_IDLE;
      grid_d   = seed_in;
      gen_d    = '0;
      stable_d = 1'b0;
      tick_d   = '0;
      row_d    = 3'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      row_q    <= 3'd0;
      grid_q   <= DEFAULT_SEED;
      shadow_q <= '0;
      gen_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      row_q    <= row_d;
      grid_q   <= grid_d;
      shadow_q <= shadow_d;
      gen_q    <= gen_d;
      stable_q <= stable_d;
    end
  end

  assign grid      = grid_q;
  assign gen_count = gen_q;
  assign stable    = stable_q;
  assign running   = (state_q != ST_IDLE);
  assign busy      = (state_q == ST_CALC) || (state_q == ST_COMMIT);

endmodule

// File: tb/tb_life_gen_controller.sv
// tb/tb_life_gen_controller.sv - randomized and directed bench for life_gen_controller
module tb_life_gen_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        randomize = 1'b0;
  logic        pause = 1'b0;
  logic [63:0] seed_in = 64'h0;
  logic [63:0] grid;
  logic        running;
  logic        busy;
  logic        stable;
  logic [15:0] gen_count;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] DEF_GRID = 64'h0412_6424_0034_3C28;

  always #5 clk = ~clk;

  life_gen_controller #(.TICK_DIV(4), .GEN_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .randomize (randomize),
    .pause     (pause),
    .seed_in   (seed_in),
    .grid      (grid),
    .running   (running),
    .busy      (busy),
    .stable    (stable),
    .gen_count (gen_count)
  );

  function automatic logic [63:0] model_next(input logic [63:0] g);
    logic [63:0] n;
    n = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              int rr;
              int cc;
              rr = (r + dr + 8) % 8;
              cc = (c + dc + 8) % 8;
              cnt += int'(g[rr*8+cc]);
            end
          end
        end
        n[r*8+c] = (cnt == 3) || (g[r*8+c] && cnt == 2);
      end
    end
    return n;
  endfunction

  task automatic load(input logic [63:0] s);
    @(negedge clk);
    randomize = 1'b1;
    seed_in   = s;
    @(negedge clk);
    randomize = 1'b0;
    n_cmp++;
    if (grid !== s || gen_count !== 16'd0 || running !== 1'b0 || stable !== 1'b0) begin
      n_err++;
      $display("FAIL load: grid=%h gen=%0d running=%b stable=%b, want grid=%h gen=0 running=0 stable=0",
               grid, gen_count, running, stable, s);
    end
  endtask

  task automatic go();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges until busy has been seen high and then dropped again.
  task automatic wait_gen(input bit rand_pause, output int ncyc, output int nbusy);
    bit seen;
    bit done;
    seen  = 1'b0;
    done  = 1'b0;
    ncyc  = 0;
    nbusy = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      ncyc++;
      if (busy) begin
        seen = 1'b1;
        nbusy++;
      end else if (seen) begin
        done = 1'b1;
      end
      if (!done) pause = rand_pause ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    pause = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_gen_timeout: no generation completed in %0d cycles, want completion", ncyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (grid !== DEF_GRID) begin n_err++; $display("FAIL reset_grid: got %h want %h", grid, DEF_GRID); end
    n_cmp++;
    if (gen_count !== 16'd0) begin n_err++; $display("FAIL reset_gen: got %0d want 0", gen_count); end
    n_cmp++;
    if (running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b want 0", running); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++;
    if (stable !== 1'b0) begin n_err++; $display("FAIL reset_stable: got %b want 0", stable); end
  endtask

  task automatic test_blinker();
    int nc, nb;
    load(64'h0000_0000_1C00_0000);
    go();
    n_cmp++;
    if (running !== 1'b1) begin n_err++; $display("FAIL blinker_running: got %b want 1", running); end
    wait_gen(1'b0, nc, nb);
    n_cmp++;
    if (grid !== 64'h0000_0008_0808_0000 || gen_count !== 16'd1) begin
      n_err++;
      $display("FAIL blinker_gen1: grid=%h gen=%0d want grid=0000000808080000 gen=1", grid, gen_count);
    end
    n_cmp++;
    if (nb !== 9) begin n_err++; $display("FAIL blinker_busy_len: got %0d want 9", nb); end
    wait_gen(1'b0, nc, nb);
    n_cmp++;
    if (grid !== 64'h0000_0000_1C00_0000 || stable !== 1'b0 || running !== 1'b1 || gen_count !== 16'd2) begin
      n_err++;
      $display("FAIL blinker_gen2: grid=%h stable=%b running=%b gen=%0d want 000000001c000000 0 1 2",
               grid, stable, running, gen_count);
    end
    n_cmp++;
    if (nc !== 13) begin n_err++; $display("FAIL blinker_period: got %0d want 13", nc); end
  endtask

  task automatic test_wrap();
    int nc, nb;
    load(64'h0000_0000_8300_0000);
    go();
    wait_gen(1'b0, nc, nb);
    n_cmp++;
    if (grid !== 64'h0000_0001_0101_0000) begin
      n_err++;
      $display("FAIL wrap_gen1: got %h want 0000000101010000", grid);
    end
  endtask

  task automatic test_still_life();
    int nc, nb;
    load(64'h0000_0000_0000_0303);
    go();
    wait_gen(1'b0, nc, nb);
    n_cmp++;
    if (grid !== 64'h0000_0000_0000_0303 || stable !== 1'b1 || gen_count !== 16'd1 || running !== 1'b0) begin
      n_err++;
      $display("FAIL still_life: grid=%h stable=%b gen=%0d running=%b want 0000000000000303 1 1 0",
               grid, stable, gen_count, running);
    end
  endtask

  task automatic test_pause_abort();
    int nc, nb;
    bit busy_seen;
    int after;
    logic [63:0] s2;
    load(64'h0000_0000_1C00_0000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    pause = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    n_cmp++;
    if (busy_seen || running !== 1'b1) begin
      n_err++;
      $display("FAIL pause_hold: busy_seen=%b running=%b want 0 1", busy_seen, running);
    end
    pause = 1'b0;
    after = 0;
    for (int i = 0; i < 50 && !busy; i++) begin
      @(negedge clk);
      after++;
    end
    n_cmp++;
    if (after !== 3) begin n_err++; $display("FAIL pause_resume: busy after %0d cycles want 3", after); end
    wait_gen(1'b0, nc, nb);
    n_cmp++;
    if (grid !== 64'h0000_0008_0808_0000 || gen_count !== 16'd1) begin
      n_err++;
      $display("FAIL pause_gen1: grid=%h gen=%0d want 0000000808080000 1", grid, gen_count);
    end
    for (int i = 0; i < 50 && !busy; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    s2 = {$urandom, $urandom};
    randomize = 1'b1;
    seed_in   = s2;
    @(negedge clk);
    randomize = 1'b0;
    n_cmp++;
    if (running !== 1'b0 || busy !== 1'b0 || grid !== s2 || gen_count !== 16'd0) begin
      n_err++;
      $display("FAIL abort: running=%b busy=%b grid=%h gen=%0d want 0 0 %h 0",
               running, busy, grid, gen_count, s2);
    end
  endtask

  task automatic test_empty_reset();
    int nc, nb;
    load(64'h0);
    go();
    wait_gen(1'b0, nc, nb);
    n_cmp++;
    if (grid !== 64'h0 || stable !== 1'b1 || running !== 1'b0 || gen_count !== 16'd1) begin
      n_err++;
      $display("FAIL empty: grid=%h stable=%b running=%b gen=%0d want 0 1 0 1", grid, stable, running, gen_count);
    end
    load(64'h0000_0000_1C00_0000);
    go();
    for (int i = 0; i < 50 && !busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (grid !== DEF_GRID || running !== 1'b0 || busy !== 1'b0 || gen_count !== 16'd0 || stable !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_calc: grid=%h running=%b busy=%b gen=%0d stable=%b want %h 0 0 0 0",
               grid, running, busy, gen_count, stable, DEF_GRID);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    int nc, nb;
    logic [63:0] s, cur, nxt;
    bit st;
    for (int k = 0; k < 8; k++) begin
      s = {$urandom, $urandom};
      if (k % 2 == 1) s = s & {$urandom, $urandom};
      load(s);
      go();
      cur = s;
      st  = 1'b0;
      for (int g = 1; g <= 5 && !st; g++) begin
        wait_gen(1'b1, nc, nb);
        nxt = model_next(cur);
        st  = (nxt == cur);
        n_cmp++;
        if (grid !== nxt || gen_count !== 16'(g) || stable !== st || running !== !st || nb !== 9) begin
          n_err++;
          $display("FAIL random_gen: seed=%h g=%0d grid=%h gen=%0d stable=%b running=%b busy_len=%0d want %h %0d %b %b 9",
                   s, g, grid, gen_count, stable, running, nb, nxt, g, st, !st);
        end
        cur = nxt;
      end
    end
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_wrap();
    test_still_life();
    test_pause_abort();
    test_empty_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
